// File: rtl/mips_pkg.sv
// Shared constants and state encoding for the pipeline sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

  localparam int N_BITS_DEF       = 32;
  localparam int N_BITS_REG_DEF   = 5;
  localparam int DRAIN_CYCLES_DEF = 4;
  // Wide enough for DRAIN_CYCLES-1 over the legal range 1..15.
  localparam int DRAIN_CNT_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } seq_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: flags a stall when the load in EX feeds ID.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the stall output is the backpressure source itself.
module hazard_detect
  import mips_pkg::*;
#(
  parameter int N_BITS_REG = N_BITS_REG_DEF
) (
  input  logic                  stage_valid,
  input  logic                  ex_mem_read,
  input  logic [N_BITS_REG-1:0] ex_rt,
  input  logic [N_BITS_REG-1:0] id_rs,
  input  logic [N_BITS_REG-1:0] id_rt,
  output logic                  stall
);

  // Register 0 is hardwired, so a load into it never creates a dependency.
  assign stall = stage_valid & ex_mem_read & (ex_rt != '0) &
                 ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_sequencer.sv
// Run/step/halt sequencer for the 5-stage pipeline with load-use stall control.
// Latency: control outputs are combinational from state; state moves on posedge.
// Backpressure: a load-use stall freezes PC and IF/ID and defers flush and halt.
module pipeline_sequencer
  import mips_pkg::*;
#(
  parameter int N_BITS       = N_BITS_DEF,
  parameter int N_BITS_REG   = N_BITS_REG_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic                  i_step,
  input  logic                  i_halt_detected,
  input  logic                  i_ex_mem_read,
  input  logic [N_BITS_REG-1:0] i_ex_rt,
  input  logic [N_BITS_REG-1:0] i_id_rs,
  input  logic [N_BITS_REG-1:0] i_id_rt,
  input  logic                  i_branch_taken,
  output logic                  o_stage_valid,
  output logic                  o_pc_write,
  output logic                  o_if_id_write,
  output logic                  o_id_ex_bubble,
  output logic                  o_flush_if_id,
  output logic                  o_halted,
  output logic [2:0]            o_state,
  output logic [N_BITS-1:0]     o_cycle_count
);

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_ONE  = DRAIN_CNT_W'(1);
  localparam logic [N_BITS-1:0]      CNT_ONE    = N_BITS'(1);

  seq_state_e             state_q, state_d;
  logic [DRAIN_CNT_W-1:0] drain_q, drain_d;
  logic [N_BITS-1:0]      cycle_q;
  logic                   stage_valid;
  logic                   stall;

  // Stages advance only while the sequencer is actively running or draining.
  assign stage_valid = (state_q == ST_RUN) || (state_q == ST_STEP) ||
                       (state_q == ST_DRAIN);

  hazard_detect #(
    .N_BITS_REG (N_BITS_REG)
  ) u_hazard_detect (
    .stage_valid (stage_valid),
    .ex_mem_read (i_ex_mem_read),
    .ex_rt       (i_ex_rt),
    .id_rs       (i_id_rs),
    .id_rt       (i_id_rt),
    .stall       (stall)
  );

  // State, drain counter and cycle counter registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      // Saturate so a long debug session never wraps back to a small count.
      if (stage_valid && (cycle_q != '1)) begin
        cycle_q <= cycle_q + CNT_ONE;
      end
    end
  end

  // Next-state selection and per-state pipeline control.
  always_comb begin
    state_d        = state_q;
    drain_d        = drain_q;
    o_pc_write     = 1'b0;
    o_if_id_write  = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_halted       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_mode && i_step) begin
          state_d = ST_STEP;
        end else if (!i_mode && i_start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN, ST_STEP: begin
        o_pc_write     = ~stall;
        o_if_id_write  = ~stall;
        o_id_ex_bubble = stall;
        // A HALT held behind a stall is taken once the stall clears.
        if (i_halt_detected && !stall) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (state_q == ST_STEP) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        o_id_ex_bubble = stall;
        if (drain_q == '0) begin
          state_d = ST_HALTED;
        end else begin
          drain_d = drain_q - DRAIN_ONE;
        end
      end
      ST_HALTED: begin
        o_halted = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A taken branch squashes IF/ID only once the stall has released it.
  assign o_flush_if_id = i_branch_taken & stage_valid & ~stall;
  assign o_stage_valid = stage_valid;
  assign o_state       = state_q;
  assign o_cycle_count = cycle_q;

endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 Parameter N_BITS, default 32, width of the cycle counter.
REQ-002 Parameter N_BITS_REG, default 5, register-select width.
REQ-003 Parameter DRAIN_CYCLES, default 4, cycles needed to empty the pipeline after HALT; range 1..15.
REQ-004 Ports SHALL be as follows; one clock; reset is asynchronous and active-low.
- i_clock  in  1  pipeline clock, all state on posedge.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  debug unit run request, level, sampled in IDLE.
- i_mode  in  1  0 = continuous, 1 = single-step.
- i_step  in  1  single-cycle step pulse; used when i_mode=1.
- i_halt_detected  in  1  decode stage holds the HALT opcode.
- i_ex_mem_read  in  1  the instruction in EX is a load.
- i_ex_rt  in  N_BITS_REG  load destination register in EX.
- i_id_rs  in  N_BITS_REG  rs of the instruction in ID.
- i_id_rt  in  N_BITS_REG  rt of the instruction in ID.
- i_branch_taken  in  1  branch/jump resolved taken.
- o_stage_valid  out  1  drives i_valid of all stages.
- o_pc_write  out  1  PC update enable.
- o_if_id_write  out  1  IF/ID latch enable.
- o_id_ex_bubble  out  1  zero the ID/EX control fields.
- o_flush_if_id  out  1  squash the IF/ID contents.
- o_halted  out  1  program finished.
- o_state  out  3  current FSM state encoding.
- o_cycle_count  out  N_BITS  count of advanced cycles.

Function
REQ-005 The FSM SHALL have the states IDLE=0, RUN=1, STEP=2, DRAIN=3 and HALTED=4, registered on posedge i_clock.
REQ-006 From IDLE, the FSM SHALL go to RUN if i_start=1 and i_mode=0, and to STEP if i_mode=1 and i_step=1; otherwise it stays in IDLE.
REQ-007 STEP SHALL last exactly one cycle and then return to IDLE, unless the halt condition of REQ-010 applies.
REQ-008 RUN SHALL persist until the halt condition; i_start, i_step and i_mode SHALL be ignored outside IDLE.
REQ-009 o_stage_valid SHALL be 1 in RUN, STEP and DRAIN and 0 in IDLE and HALTED.
REQ-010 The halt condition is (RUN or STEP) and i_halt_detected=1 and no stall; it moves the FSM to DRAIN and loads the drain counter with DRAIN_CYCLES-1.
REQ-011 In DRAIN, o_pc_write and o_if_id_write SHALL be 0.
REQ-012 In DRAIN, the drain counter SHALL decrement each cycle; when it is 0, the next state SHALL be HALTED.
REQ-013 HALTED SHALL be terminal until reset, with o_halted=1.
REQ-014 stall SHALL be computed combinationally as o_stage_valid & i_ex_mem_read & (i_ex_rt!=0) & (i_ex_rt==i_id_rs | i_ex_rt==i_id_rt).
REQ-015 When stall=1: o_pc_write=0, o_if_id_write=0 and o_id_ex_bubble=1.
REQ-016 When stall=0 in RUN or STEP: o_pc_write=1, o_if_id_write=1 and o_id_ex_bubble=0.
REQ-017 o_flush_if_id SHALL equal i_branch_taken & o_stage_valid & ~stall; on a simultaneous branch and stall, the stall wins and the flush is deferred.
REQ-018 o_cycle_count SHALL increment on every clock edge where o_stage_valid=1, and SHALL saturate at all-ones.
REQ-019 With stall=1 and i_halt_detected=1 in the same cycle, the halt SHALL be taken on the first non-stall cycle.

Reset
REQ-020 Asserting i_reset low SHALL immediately force state=IDLE, drain counter=0 and o_cycle_count=0, independent of i_clock.
REQ-021 During reset all outputs SHALL be 0, including mid-DRAIN and in HALTED.
REQ-022 Reset release SHALL take effect on the first posedge after i_reset rises.

Structure
REQ-023 The state encodings, DRAIN_CYCLES default and register-width constants SHALL live in the shared package mips_pkg.
REQ-024 The hazard comparator SHALL be one sub-module, hazard_detect, which is purely combinational and outputs stall; the FSM and the counters stay in pipeline_sequencer.

Verification
REQ-025 Reset low mid-RUN at cycle 7 -> o_state=0, o_cycle_count=0 and all outputs 0 with no clock edge.
REQ-026 i_mode=1 with three i_step pulses -> o_stage_valid high for exactly 3 cycles and o_cycle_count=3.
REQ-027 RUN, i_ex_mem_read=1, i_ex_rt=8, i_id_rs=8 for one cycle -> o_pc_write=0, o_id_ex_bubble=1 that cycle and the count still increments; with i_ex_rt=0 there is no stall.
REQ-028 Stall and i_branch_taken in the same cycle -> o_flush_if_id=0; the next cycle, with the branch held and no stall -> o_flush_if_id=1.
REQ-029 i_halt_detected in RUN with DRAIN_CYCLES=4 -> 4 DRAIN cycles with o_pc_write=0, then o_halted=1 and o_stage_valid=0 permanently; i_start is then ignored.
REQ-030 o_cycle_count preset near all-ones (N_BITS=4 build) -> the count saturates at 15.
